// File: rtl/alu_fpu_seq.sv
// alu_fpu_seq: issue sequencer that stalls the pipeline for the latency of multi-cycle FP ops and flags result write-back; optional perf counters under macro ALU_SEQ_PERF_EN
module alu_fpu_seq #(
  parameter int CNT_W     = 4,
  parameter int LAT_CMP   = 1,
  parameter int LAT_ARITH = 2,
  parameter int LAT_DIV   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [6:0]       aluctl,
  input  logic             flush_in,
  output logic             issue_ready,
  output logic             alu_nstall,
  output logic             res_valid,
  output logic             busy,
  output logic [CNT_W-1:0] res_lat,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      fp_ops
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, lat;
  logic accept, unused_ok;
  assign unused_ok = aluctl[6];
  always_comb begin
    case (aluctl[5:0])
      6'b010000, 6'b010001, 6'b010010, 6'b010100: lat = CNT_W'(LAT_ARITH);
      6'b010011:                                  lat = CNT_W'(LAT_DIV);
      6'b010110, 6'b010111, 6'b011001, 6'b011010: lat = CNT_W'(LAT_CMP);
      default:                                    lat = '0;
    endcase
  end
  assign accept      = issue_valid & (state == IDLE) & ~flush_in;
  assign issue_ready = rst | (state == IDLE);
  assign busy        = ~rst & (state == WAIT);
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    alu_nstall = 1'b1;
    res_valid  = 1'b0;
    if (state == IDLE) begin
      res_valid  = accept & (lat == '0);
      alu_nstall = ~(accept & (lat != '0));
      if (accept && lat != '0) begin
        state_nx = WAIT;
        cnt_nx   = lat - 1'b1;
      end
    end else begin
      alu_nstall = flush_in | (cnt == '0);
      res_valid  = ~flush_in & (cnt == '0);
      if (flush_in || cnt == '0) state_nx = IDLE;
      else cnt_nx = cnt - 1'b1;
    end
    if (rst) begin
      alu_nstall = 1'b1;
      res_valid  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      res_lat <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) res_lat <= lat;
    end
  end
`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      fp_ops       <= '0;
    end else begin
      if (!alu_nstall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (accept && aluctl[5:4] == 2'b01 && fp_ops != '1) fp_ops <= fp_ops + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign fp_ops       = '0;
`endif
endmodule
